// File: rtl/ysyx_exu_lsq.sv
// In-order load/store queue: buffers EXU memory ops, issues one bus access at a time
// from the head, holds speculative ops until commit, and returns extended load data.
module ysyx_exu_lsq #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int RD_W  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic                       req_wen_i,
    input  logic [XLEN-1:0]            req_addr_i,
    input  logic [XLEN-1:0]            req_wdata_i,
    input  logic [2:0]                 req_func3_i,
    input  logic [RD_W-1:0]            req_rd_i,
    input  logic                       req_spec_i,
    input  logic                       commit_i,
    input  logic                       flush_i,
    output logic                       bus_avalid_o,
    input  logic                       bus_aready_i,
    output logic                       bus_wen_o,
    output logic [XLEN-1:0]            bus_addr_o,
    output logic [XLEN-1:0]            bus_wdata_o,
    output logic [XLEN/8-1:0]          bus_wstrb_o,
    input  logic                       bus_rvalid_i,
    input  logic [XLEN-1:0]            bus_rdata_i,
    input  logic                       bus_wready_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic                       rsp_wen_o,
    output logic [RD_W-1:0]            rsp_rd_o,
    output logic [XLEN-1:0]            rsp_data_o,
    output logic                       rsp_err_o,
    output logic [1:0]                 dbg_state_o,
    output logic [$clog2(DEPTH):0]     dbg_count_o
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // a valid side holds its payload stable until that edge and never withdraws early.

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RSP = 2'd3} state_e;

    typedef struct packed {
        logic            wen;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [2:0]      func3;
        logic [RD_W-1:0] rd;
    } entry_t;

    state_e          state_q, state_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] spec_q, spec_d;
    entry_t          ent_q [DEPTH];
    entry_t          ent_d [DEPTH];
    logic            rsp_wen_q, rsp_wen_d;
    logic            rsp_err_q, rsp_err_d;
    logic [RD_W-1:0] rsp_rd_q, rsp_rd_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;

    entry_t           head_ent;
    logic [OFF_W-1:0] head_off;
    logic             misaligned;
    logic [STRB_W-1:0] size_mask;
    logic [XLEN-1:0]  rdata_sh;
    logic [XLEN-1:0]  load_ext;
    logic [CNT_W-1:0] n_spec;
    logic             enq, pop, do_flush;

    assign head_ent = ent_q[head_q];
    assign head_off = head_ent.addr[OFF_W-1:0];

    always_comb begin
        misaligned = 1'b0;
        size_mask  = STRB_W'(1);
        case (head_ent.func3[1:0])
            2'd0: begin misaligned = 1'b0;                  size_mask = STRB_W'(8'h01); end
            2'd1: begin misaligned = head_ent.addr[0];      size_mask = STRB_W'(8'h03); end
            2'd2: begin misaligned = |head_ent.addr[1:0];   size_mask = STRB_W'(8'h0F); end
            default: begin misaligned = |head_ent.addr[2:0]; size_mask = STRB_W'(8'hFF); end
        endcase
    end

    // Read data arrives lane-positioned; move the addressed bytes down before extending.
    assign rdata_sh = bus_rdata_i >> {head_off, 3'b000};

    always_comb begin
        load_ext = rdata_sh;
        case (head_ent.func3)
            3'b000:  load_ext = XLEN'($signed(rdata_sh[7:0]));
            3'b001:  load_ext = XLEN'($signed(rdata_sh[15:0]));
            3'b010:  load_ext = XLEN'($signed(rdata_sh[31:0]));
            3'b100:  load_ext = XLEN'(rdata_sh[7:0]);
            3'b101:  load_ext = XLEN'(rdata_sh[15:0]);
            3'b110:  load_ext = XLEN'(rdata_sh[31:0]);
            default: load_ext = rdata_sh;
        endcase
    end

    always_comb begin
        n_spec = '0;
        for (int i = 0; i < DEPTH; i++) n_spec = n_spec + CNT_W'(spec_q[i]);
    end

    assign req_ready_o = rst & (count_q < CNT_W'(DEPTH)) & ~flush_i;
    assign enq         = req_valid_i & req_ready_o;
    assign pop         = (state_q == RSP) & rsp_ready_i;
    assign do_flush    = flush_i & ~commit_i;

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        spec_d     = spec_q;
        ent_d      = ent_q;
        rsp_wen_d  = rsp_wen_q;
        rsp_err_d  = rsp_err_q;
        rsp_rd_d   = rsp_rd_q;
        rsp_data_d = rsp_data_q;

        // Spec entries are the youngest, so a flush just rewinds the tail over them.
        if (commit_i) begin
            spec_d = '0;
        end else if (do_flush) begin
            spec_d = '0;
            tail_d = tail_q - PTR_W'(n_spec);
        end
        if (pop) begin
            head_d         = head_q + 1'b1;
            spec_d[head_q] = 1'b0;
        end
        if (enq) begin
            ent_d[tail_q]  = '{wen: req_wen_i, addr: req_addr_i, wdata: req_wdata_i,
                              func3: req_func3_i, rd: req_rd_i};
            spec_d[tail_q] = req_spec_i & ~commit_i;
            tail_d         = tail_q + 1'b1;
        end
        count_d = count_q + CNT_W'(enq) - CNT_W'(pop) - (do_flush ? n_spec : '0);

        case (state_q)
            IDLE: begin
                if (count_q != '0 && !spec_q[head_q]) begin
                    if (misaligned) begin
                        state_d    = RSP;
                        rsp_err_d  = 1'b1;
                        rsp_wen_d  = head_ent.wen;
                        rsp_rd_d   = head_ent.wen ? '0 : head_ent.rd;
                        rsp_data_d = '0;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: if (bus_aready_i) state_d = WAIT;
            WAIT: begin
                if (head_ent.wen) begin
                    if (bus_wready_i) begin
                        state_d    = RSP;
                        rsp_err_d  = 1'b0;
                        rsp_wen_d  = 1'b1;
                        rsp_rd_d   = '0;
                        rsp_data_d = '0;
                    end
                end else if (bus_rvalid_i) begin
                    state_d    = RSP;
                    rsp_err_d  = 1'b0;
                    rsp_wen_d  = 1'b0;
                    rsp_rd_d   = head_ent.rd;
                    rsp_data_d = load_ext;
                end
            end
            RSP: begin
                if (rsp_ready_i) begin
                    state_d    = IDLE;
                    rsp_err_d  = 1'b0;
                    rsp_wen_d  = 1'b0;
                    rsp_rd_d   = '0;
                    rsp_data_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            spec_q     <= '0;
            rsp_wen_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_rd_q   <= '0;
            rsp_data_q <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            spec_q     <= spec_d;
            rsp_wen_q  <= rsp_wen_d;
            rsp_err_q  <= rsp_err_d;
            rsp_rd_q   <= rsp_rd_d;
            rsp_data_q <= rsp_data_d;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
        end
    end

    assign bus_avalid_o = (state_q == REQ);
    assign bus_wen_o    = bus_avalid_o & head_ent.wen;
    assign bus_addr_o   = bus_avalid_o ? head_ent.addr : '0;
    assign bus_wdata_o  = (bus_avalid_o & head_ent.wen) ? (head_ent.wdata << {head_off, 3'b000}) : '0;
    assign bus_wstrb_o  = (bus_avalid_o & head_ent.wen) ? (size_mask << head_off) : '0;

    assign rsp_valid_o  = (state_q == RSP);
    assign rsp_wen_o    = rsp_wen_q;
    assign rsp_err_o    = rsp_err_q;
    assign rsp_rd_o     = rsp_rd_q;
    assign rsp_data_o   = rsp_data_q;

    assign dbg_state_o  = state_q;
    assign dbg_count_o  = count_q;

endmodule

// File: doc/ysyx_exu_lsq.md
Name: ysyx_exu_lsq

Overview:
Parametrised, in-order load/store queue between the EXU address stage and the data bus, replacing the single-access blocking LSU path. It buffers up to DEPTH memory ops and issues one bus transaction at a time from the head. Speculative ops are held back until committed, and can be squashed on flush. Load data is returned aligned and sign/zero-extended, tagged with its rd.

Parameters:
XLEN, 32, data/address width (32 or 64)
DEPTH, 4, queue entries (power of 2, >=2)
RD_W, 4, destination register tag width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
req_valid_i  in  1  EXU offers op
req_ready_o  out  1  queue accepts op
req_wen_i  in  1  1=store, 0=load
req_addr_i  in  XLEN  byte address
req_wdata_i  in  XLEN  store data, LSB-aligned
req_func3_i  in  3  RV func3 (size/sign)
req_rd_i  in  RD_W  load destination
req_spec_i  in  1  op is speculative
commit_i  in  1  clear spec on all entries
flush_i  in  1  drop all spec entries
bus_avalid_o  out  1  bus request valid
bus_aready_i  in  1  bus accepts request
bus_wen_o  out  1  request is write
bus_addr_o  out  XLEN  address
bus_wdata_o  out  XLEN  lane-shifted store data
bus_wstrb_o  out  XLEN/8  byte strobes
bus_rvalid_i  in  1  read data valid
bus_rdata_i  in  XLEN  read data
bus_wready_i  in  1  write complete
rsp_valid_o  out  1  completion valid
rsp_ready_i  in  1  consumer accepts
rsp_wen_o  out  1  completion was store
rsp_rd_o  out  RD_W  load rd (0 for stores)
rsp_data_o  out  XLEN  extended load data (0 for stores)
rsp_err_o  out  1  misaligned access

Behaviour:
- Reset (rst=0, async): head/tail/count=0, FSM=IDLE; all outputs 0 except req_ready_o=1 once out of reset.
- Circular buffer, head/tail wrap mod DEPTH; count 0..DEPTH.
- req_ready_o = (count<DEPTH) & !flush_i. Enqueue on req_valid_i & req_ready_o. No bypass: an op enqueued at cycle t reaches the bus at t+1 at the earliest.
- Spec entries are always the youngest and contiguous. EXU guarantees this; behaviour is undefined otherwise.
- commit_i: clear every spec bit, including on an entry enqueued in the same cycle. If commit_i and flush_i are both high, commit wins and the flush is a no-op.
- flush_i: tail rewinds past all spec entries and count decrements accordingly. The head can only be spec while in IDLE, so the in-flight op is never killed.
- FSM, states IDLE, REQ, WAIT, RSP:
  - IDLE -> REQ when count>0 & head not spec & head aligned.
  - IDLE -> RSP with rsp_err_o=1, no bus access, when the head is misaligned. Misaligned means: half with addr[0]!=0, word with addr[1:0]!=0, double with addr[2:0]!=0.
  - REQ: bus_avalid_o=1 and bus_* held stable until bus_aready_i; then -> WAIT.
  - WAIT: load -> RSP on bus_rvalid_i, capturing bus_rdata_i; store -> RSP on bus_wready_i.
  - RSP: rsp_valid_o=1, fields stable until rsp_ready_i; then pop head, head++, -> IDLE.
- Throughput: at most 1 op per 4 cycles with zero bus latency.
- Store lanes: off = addr[log2(XLEN/8)-1:0].
  - bus_wdata_o = wdata << (8*off).
  - bus_wstrb_o = size mask (b/h/w/d = 1/3/F/FF) << off.
  - bus_addr_o = full address.
- Load extension: shift bus_rdata_i right by 8*off, then extend by func3.
  - 000 LB, 001 LH, 010 LW: sign-extend.
  - 100 LBU, 101 LHU, 110 LWU (XLEN=64 only): zero-extend.
  - 011 LD: XLEN=64 only.
- Full and flush in the same cycle: no enqueue that cycle.
- Pop and enqueue in the same cycle: count unchanged.
- Reset mid-transaction: bus_avalid_o drops immediately and the queue is emptied; the bus side must tolerate the abandoned request.

Test Plan:
- Store then load through the queue: SW 0xDEADBEEF @0x80000004, then LW rd=5 @0x80000004 -> bus_wstrb_o=0xF, bus_wdata_o=0xDEADBEEF. Load response: rsp_rd_o=5, rsp_data_o=0xDEADBEEF.
- Byte load extension: bus_rdata_i=0x80FF7F01, LB @addr[1:0]=3 -> 0xFFFFFF80; LBU @addr[1:0]=3 -> 0x00000080; LH @addr[1:0]=2 -> 0xFFFF80FF.
- Fill, stall and drain: DEPTH=4, bus_aready_i=0, push 4 loads -> req_ready_o=0 after the 4th. Release the bus -> responses come back in order, and req_ready_o=1 the cycle after the first pop.
- Speculation: push 2 non-spec + 2 spec, assert flush_i -> count=2 and only 2 bus transactions occur. Repeat with commit_i instead -> 4 transactions.
- Misaligned access: SH @0x80000001 -> no bus_avalid_o, rsp_err_o=1, rsp_wen_o=1.
- Async reset: assert rst low during REQ -> bus_avalid_o=0 in the same cycle (before any clk edge); after release, req_ready_o=1 and count=0.
